// File: rtl/dfp96_unpack_norm_pkg.sv
// DFPPkg: shared types, constants and the DFP96 unpack helper for the
// DFP96 arithmetic datapath front end.
//
// Packed DFP96 layout (96 bits):
//   [95]    sign
//   [94:90] combination field G
//           G[4:1]==4'b1111 : special (G[0]=0 infinity, G[0]=1 NaN, signalling if [89]=1)
//           G[4:3]==2'b11   : exp[11:10]=G[2:1], MSD=8+G[0]
//           otherwise       : exp[11:10]=G[4:3], MSD=G[2:0]
//   [89:80] exponent continuation exp[9:0]
//   [79:0]  eight DPD declets holding the 24 trailing digits
package DFPPkg;

    localparam int DFP_N = 25;
    localparam logic [11:0] DFP96_EXP_INF = 12'hBFF;

    typedef logic [95:0] DFP96;

    typedef struct packed {
        logic                  sign;
        logic [11:0]           exp;
        logic [DFP_N*4-1:0]    dig;
        logic                  nan;
        logic                  qnan;
        logic                  snan;
        logic                  infinity;
    } DFP96U;

    typedef struct packed {
        logic                  sign;
        logic [11:0]           exp;
        logic [(DFP_N+1)*4-1:0] sig;
        logic                  nan;
        logic                  qnan;
        logic                  snan;
        logic                  infinity;
    } DFP96UN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UNPK = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } dfp_norm_state_t;

    // Densely-packed-decimal declet to three BCD digits.
    function automatic logic [11:0] dpd_dec(input logic [9:0] d);
        logic p, q, r, s, t, u, v, w, x, y;
        logic [11:0] res;
        {p, q, r, s, t, u, v, w, x, y} = d;
        if (!v) begin
            res = {1'b0, p, q, r, 1'b0, s, t, u, 1'b0, w, x, y};
        end else begin
            case ({w, x})
                2'b00:   res = {1'b0, p, q, r, 1'b0, s, t, u, 3'b100, y};
                2'b01:   res = {1'b0, p, q, r, 3'b100, u, 1'b0, s, t, y};
                2'b10:   res = {3'b100, r, 1'b0, s, t, u, 1'b0, p, q, y};
                default: begin
                    case ({s, t})
                        2'b00:   res = {3'b100, r, 3'b100, u, 1'b0, p, q, y};
                        2'b01:   res = {3'b100, r, 1'b0, p, q, u, 3'b100, y};
                        2'b10:   res = {1'b0, p, q, r, 3'b100, u, 3'b100, y};
                        default: res = {3'b100, r, 3'b100, u, 3'b100, y};
                    endcase
                end
            endcase
        end
        return res;
    endfunction

    // Split a packed DFP96 into sign, exponent, BCD digits and class flags.
    function automatic DFP96U DFPUnpack96(input DFP96 x);
        DFP96U u;
        logic [4:0] g;
        u = '0;
        g = x[94:90];
        u.sign = x[95];
        for (int k = 0; k < 8; k++) begin
            u.dig[k*12 +: 12] = dpd_dec(x[k*10 +: 10]);
        end
        if (g[4:1] == 4'b1111) begin
            u.exp          = DFP96_EXP_INF;
            u.dig[99:96]   = 4'h0;
            u.infinity     = ~g[0];
            u.nan          = g[0];
            u.snan         = g[0] & x[89];
            u.qnan         = g[0] & ~x[89];
        end else if (g[4:3] == 2'b11) begin
            u.exp          = {g[2:1], x[89:80]};
            u.dig[99:96]   = {3'b100, g[0]};
        end else begin
            u.exp          = {g[4:3], x[89:80]};
            u.dig[99:96]   = {1'b0, g[2:0]};
        end
        return u;
    endfunction

endpackage

// File: rtl/dfp96_unpack_norm_lzdc.sv
// dfp_lzdc: combinational leading-zero-digit counter over N BCD digits.
// Only instantiated when DFP_NORM_FAST_EN is defined.
module dfp_lzdc #(
    parameter int N = 25,
    parameter int W = $clog2(N)
) (
    input  logic [N*4-1:0] dig,
    output logic [W-1:0]   cnt
);

    logic found_s;

    // Count zero digits from the MSD down until the first non-zero digit.
    always_comb begin
        cnt     = '0;
        found_s = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (!found_s && (dig[k*4 +: 4] == 4'h0)) begin
                cnt = cnt + {{(W-1){1'b0}}, 1'b1};
            end else begin
                found_s = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dfp96_unpack_norm.sv
// dfp96_unpack_norm: unpacks a DFP96 operand and left-normalises its
// significand so that the MSD is non-zero (or the exponent reaches 0).
// Macro DFP_NORM_FAST_EN selects a fixed-latency single-shift normaliser;
// without it, normalisation shifts one digit per cycle.
module dfp96_unpack_norm
    import DFPPkg::*;
#(
    parameter int N = DFP_N
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    output logic        rdy,
    input  logic [95:0] i,
    output DFP96UN      o,
    output logic [4:0]  lzd,
    output logic        zero,
    output logic        valid,
    input  logic        o_ready
);

    localparam logic [4:0] LZD_MAX = 5'(N - 1);

    dfp_norm_state_t state_r, state_nx_s;
    logic [95:0]     opnd_r, opnd_nx_s;
    DFP96UN          o_r, o_nx_s;
    logic [4:0]      lzd_r, lzd_nx_s;
    logic            zero_r, zero_nx_s;
    logic            valid_r, valid_nx_s;
    logic            rdy_r, rdy_nx_s;
    DFP96U           unpk_s;
    logic            msd_zero_s;
    logic            sig_zero_s;
    logic            special_s;

`ifdef DFP_NORM_FAST_EN
    logic            ph_r, ph_nx_s;
    logic [4:0]      amt_r, amt_nx_s;
    logic [4:0]      lzc_s;

    dfp_lzdc #(.N(N), .W(5)) u_lzdc (
        .dig (o_r.sig[(N+1)*4-1:4]),
        .cnt (lzc_s)
    );
`endif

    assign unpk_s     = DFPUnpack96(opnd_r);
    assign msd_zero_s = (o_r.sig[(N+1)*4-1 -: 4] == 4'h0);
    assign sig_zero_s = (o_r.sig == '0);
    assign special_s  = o_r.nan | o_r.infinity;

    // Next-state and next-register computation for the unpack/normalise FSM.
    always_comb begin
        state_nx_s = state_r;
        opnd_nx_s  = opnd_r;
        o_nx_s     = o_r;
        lzd_nx_s   = lzd_r;
        zero_nx_s  = zero_r;
        valid_nx_s = valid_r;
        rdy_nx_s   = rdy_r;
`ifdef DFP_NORM_FAST_EN
        ph_nx_s    = ph_r;
        amt_nx_s   = amt_r;
`endif
        case (state_r)
            IDLE: begin
                if (ld) begin
                    opnd_nx_s  = i;
                    rdy_nx_s   = 1'b0;
                    state_nx_s = UNPK;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            UNPK: begin
                o_nx_s.sign     = unpk_s.sign;
                o_nx_s.exp      = unpk_s.exp;
                o_nx_s.sig      = {unpk_s.dig, 4'h0};
                o_nx_s.nan      = unpk_s.nan;
                o_nx_s.qnan     = unpk_s.qnan;
                o_nx_s.snan     = unpk_s.snan;
                o_nx_s.infinity = unpk_s.infinity;
                lzd_nx_s        = 5'd0;
                zero_nx_s       = 1'b0;
`ifdef DFP_NORM_FAST_EN
                ph_nx_s         = 1'b0;
`endif
                state_nx_s      = NORM;
            end
            NORM: begin
`ifdef DFP_NORM_FAST_EN
                // Phase 0 sizes the shift, phase 1 applies it in one step.
                if (!ph_r) begin
                    if (special_s || sig_zero_s) begin
                        amt_nx_s = 5'd0;
                    end else if ({7'd0, lzc_s} > o_r.exp) begin
                        amt_nx_s = o_r.exp[4:0];
                    end else begin
                        amt_nx_s = lzc_s;
                    end
                    ph_nx_s = 1'b1;
                end else begin
                    o_nx_s.sig = o_r.sig << {amt_r, 2'b00};
                    o_nx_s.exp = o_r.exp - {7'd0, amt_r};
                    lzd_nx_s   = amt_r;
                    zero_nx_s  = sig_zero_s;
                    valid_nx_s = 1'b1;
                    ph_nx_s    = 1'b0;
                    state_nx_s = DONE;
                end
`else
                if (special_s || sig_zero_s) begin
                    zero_nx_s  = sig_zero_s;
                    valid_nx_s = 1'b1;
                    state_nx_s = DONE;
                end else if (msd_zero_s && (o_r.exp != 12'd0)) begin
                    o_nx_s.sig = {o_r.sig[(N+1)*4-5:0], 4'h0};
                    o_nx_s.exp = o_r.exp - 12'd1;
                    if (lzd_r == LZD_MAX) begin
                        lzd_nx_s = lzd_r;
                    end else begin
                        lzd_nx_s = lzd_r + 5'd1;
                    end
                end else begin
                    valid_nx_s = 1'b1;
                    state_nx_s = DONE;
                end
`endif
            end
            DONE: begin
                if (o_ready) begin
                    valid_nx_s = 1'b0;
                    rdy_nx_s   = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                valid_nx_s = 1'b0;
                rdy_nx_s   = 1'b1;
                state_nx_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            opnd_r  <= 96'd0;
            o_r     <= '0;
            lzd_r   <= 5'd0;
            zero_r  <= 1'b0;
            valid_r <= 1'b0;
            rdy_r   <= 1'b1;
`ifdef DFP_NORM_FAST_EN
            ph_r    <= 1'b0;
            amt_r   <= 5'd0;
`endif
        end else begin
            state_r <= state_nx_s;
            opnd_r  <= opnd_nx_s;
            o_r     <= o_nx_s;
            lzd_r   <= lzd_nx_s;
            zero_r  <= zero_nx_s;
            valid_r <= valid_nx_s;
            rdy_r   <= rdy_nx_s;
`ifdef DFP_NORM_FAST_EN
            ph_r    <= ph_nx_s;
            amt_r   <= amt_nx_s;
`endif
        end
    end

    assign o     = o_r;
    assign lzd   = lzd_r;
    assign zero  = zero_r;
    assign valid = valid_r;
    assign rdy   = rdy_r;

endmodule
